// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus. The fetch unit is the master and the memory is the slave.
// imem_req is held high until the cycle imem_ack=1. imem_addr stays stable while imem_req=1.
// imem_rdata is valid only in the cycle where imem_ack=1.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch stage. It holds the PC, fetches one word over the imem bus,
// issues it to decode for one cycle, and steps the PC when the datapath reports completion.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   instr_fetch_unit_if.master         imem,
   output logic [31:0]                instr,
   output logic                       instr_valid,
   input  logic                       exec_done,
   input  logic                       jump,
   input  logic                       jr_sel,
   input  logic                       branch_taken,
   input  logic [31:0]                jr_target,
   output logic [31:0]                pc,
   output logic [31:0]                pc_plus4,
   output logic [31:0]                retired,
   output logic                       fetch_err,
   output logic [2:0]                 state_dbg
);

   localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      ISSUE = 3'd2,
      EXEC  = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             imem_req_r;
   logic [31:0]      next_pc;
   logic [31:0]      branch_off;
   logic             jr_misaligned;

   assign pc_plus4      = pc + 32'd4;
   assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign jr_misaligned = jr_sel && (jr_target[1:0] != 2'b00);
   assign state_dbg     = state;

   // The address comes straight from pc. pc only moves in EXEC, so it is stable while a request is open.
   assign imem.imem_req  = imem_req_r;
   assign imem.imem_addr = pc;

   always_comb begin
      next_pc = pc_plus4;
      if (jr_sel)
         next_pc = jr_target;
      else if (jump)
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (branch_taken)
         next_pc = pc_plus4 + branch_off;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         imem_req_r  <= 1'b0;
         retired     <= 32'd0;
         fetch_err   <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               state      <= REQ;
               imem_req_r <= 1'b1;
               wait_cnt   <= '0;
            end
            REQ: begin
               if (imem.imem_ack) begin
                  instr       <= imem.imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req_r  <= 1'b0;
                  wait_cnt    <= '0;
                  state       <= ISSUE;
               end else if (wait_cnt == CNT_LAST) begin
                  imem_req_r <= 1'b0;
                  fetch_err  <= 1'b1;
                  state      <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ISSUE: begin
               instr_valid <= 1'b0;
               state       <= EXEC;
            end
            EXEC: begin
               if (exec_done) begin
                  // A misaligned JR target is not committed. pc and retired keep the faulting instruction.
                  if (jr_misaligned) begin
                     fetch_err <= 1'b1;
                     state     <= ERR;
                  end else begin
                     pc         <= next_pc;
                     retired    <= retired + 32'd1;
                     wait_cnt   <= '0;
                     imem_req_r <= 1'b1;
                     state      <= REQ;
                  end
               end
            end
            ERR: begin
               fetch_err   <= 1'b1;
               imem_req_r  <= 1'b0;
               instr_valid <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               imem_req_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
